column_tex_requester: RTL and testbench

Per-column texture fetch sequencer on the requesting side of the texture sampler handshake. It accepts one ray result per screen column (line height, draw start, wallX, map cell type). It walks every row of that column, issuing one texture request per textured row and waiting for the sampler's valid pixel. It writes ceiling, wall or floor bytes into the frame buffer write port, then signals column completion to the raycaster.

---
 rtl/column_tex_requester.sv | 242 ++++++++++++++++++++++++
 tb/tb_column_tex_requester.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/column_tex_requester.sv
// Per-column texture fetch sequencer: walks every row of one screen column, requests
// sampler pixels for textured wall rows and writes ceiling/wall/floor bytes to the frame buffer.
// Optional request watchdog enabled by defining TEX_TIMEOUT_EN.
module column_tex_requester #(
  parameter int         SCREEN_WIDTH   = 320,
  parameter int         SCREEN_HEIGHT  = 180,
  parameter logic [7:0] CEIL_COLOR     = 8'h11,
  parameter logic [7:0] FLOOR_COLOR    = 8'h22,
  parameter logic [7:0] WALL_COLOR     = 8'h33,
  parameter int         TIMEOUT_CYCLES = 64
) (
  input  logic        pixel_clk_in,
  input  logic        rst_n_in,
  input  logic        ray_valid_in,
  output logic        ray_ready_out,
  input  logic [8:0]  hcount_ray_in,
  input  logic [7:0]  lineheight_in,
  input  logic [9:0]  drawstart_in,
  input  logic [15:0] wallX_in,
  input  logic [3:0]  map_data_in,
  output logic        valid_req_out,
  output logic [15:0] wallX_out,
  output logic [7:0]  lineheight_out,
  output logic [9:0]  drawstart_out,
  output logic [7:0]  vcount_ray_out,
  output logic [3:0]  texture_out,
  input  logic [7:0]  tex_pixel_in,
  input  logic        valid_tex_in,
  output logic [15:0] pix_addr_out,
  output logic [7:0]  pix_data_out,
  output logic        pix_wr_out,
  output logic        column_done_out,
  output logic        timeout_err_out
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ROW  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  row_q, row_d;
  logic [15:0] rowAddr_q, rowAddr_d;
  logic [15:0] pixAddr_q, pixAddr_d;
  logic [7:0]  pixData_q, pixData_d;
  logic        pixWr_q, pixWr_d;
  logic        req_q, req_d;
  logic [15:0] wallX_q, wallX_d;
  logic [7:0]  lineHeight_q, lineHeight_d;
  logic [9:0]  drawStart_q, drawStart_d;
  logic [3:0]  texture_q, texture_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;

`ifdef TEX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] waitCnt_q, waitCnt_d;
  logic          timeoutErr_q, timeoutErr_d;
`endif

  logic        handshake;
  logic        isLastRow;
  logic [10:0] row11, spanStart, spanEnd;
  logic        isAbove, isWall, isTextured;
  logic [7:0]  rowColor;

  // Wall span compare is done in 11 bits so drawstart + lineheight never wraps.
  always_comb begin
    row11      = {3'b000, row_q};
    spanStart  = {1'b0, drawStart_q};
    spanEnd    = {1'b0, drawStart_q} + {3'b000, lineHeight_q};
    isAbove    = row11 < spanStart;
    isWall     = !isAbove && (row11 < spanEnd);
    isTextured = (texture_q >= 4'd2) && (texture_q <= 4'd9);
    isLastRow  = row_q == 8'(SCREEN_HEIGHT - 1);
    handshake  = ready_q && ray_valid_in;
    if (isAbove) begin
      rowColor = CEIL_COLOR;
    end else if (isWall) begin
      rowColor = WALL_COLOR;
    end else begin
      rowColor = FLOOR_COLOR;
    end
  end

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    rowAddr_d    = rowAddr_q;
    pixAddr_d    = pixAddr_q;
    pixData_d    = pixData_q;
    pixWr_d      = 1'b0;
    req_d        = req_q;
    wallX_d      = wallX_q;
    lineHeight_d = lineHeight_q;
    drawStart_d  = drawStart_q;
    texture_d    = texture_q;
    done_d       = 1'b0;
    ready_d      = (state_q == S_IDLE) && !handshake;
`ifdef TEX_TIMEOUT_EN
    waitCnt_d    = waitCnt_q;
    timeoutErr_d = timeoutErr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          wallX_d      = wallX_in;
          lineHeight_d = lineheight_in;
          drawStart_d  = drawstart_in;
          texture_d    = map_data_in;
          row_d        = 8'd0;
          rowAddr_d    = 16'(hcount_ray_in);
          pixAddr_d    = 16'(hcount_ray_in);
          state_d      = S_ROW;
        end
      end

      S_ROW: begin
        if (isWall && isTextured) begin
          req_d   = 1'b1;
          state_d = S_WAIT;
`ifdef TEX_TIMEOUT_EN
          waitCnt_d = '0;
`endif
        end else begin
          pixWr_d   = 1'b1;
          pixAddr_d = rowAddr_q;
          pixData_d = rowColor;
          if (isLastRow) begin
            state_d = S_DONE;
          end else begin
            row_d     = row_q + 8'd1;
            rowAddr_d = rowAddr_q + 16'(SCREEN_WIDTH);
            state_d   = S_ROW;
          end
        end
      end

      S_WAIT: begin
        if (valid_tex_in) begin
          pixWr_d   = 1'b1;
          pixAddr_d = rowAddr_q;
          pixData_d = tex_pixel_in;
          req_d     = 1'b0;
          state_d   = S_GAP;
        end
`ifdef TEX_TIMEOUT_EN
        else if (waitCnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          pixWr_d      = 1'b1;
          pixAddr_d    = rowAddr_q;
          pixData_d    = WALL_COLOR;
          req_d        = 1'b0;
          timeoutErr_d = 1'b1;
          state_d      = S_GAP;
        end else begin
          waitCnt_d = waitCnt_q + TW'(1);
        end
`endif
      end

      // The sampler triggers on the request's rising edge, so the request must drop for a cycle.
      S_GAP: begin
        if (isLastRow) begin
          state_d = S_DONE;
        end else begin
          row_d     = row_q + 8'd1;
          rowAddr_d = rowAddr_q + 16'(SCREEN_WIDTH);
          state_d   = S_ROW;
        end
      end

      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      rowAddr_q    <= '0;
      pixAddr_q    <= '0;
      pixData_q    <= '0;
      pixWr_q      <= 1'b0;
      req_q        <= 1'b0;
      wallX_q      <= '0;
      lineHeight_q <= '0;
      drawStart_q  <= '0;
      texture_q    <= '0;
      done_q       <= 1'b0;
      ready_q      <= 1'b0;
`ifdef TEX_TIMEOUT_EN
      waitCnt_q    <= '0;
      timeoutErr_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      rowAddr_q    <= rowAddr_d;
      pixAddr_q    <= pixAddr_d;
      pixData_q    <= pixData_d;
      pixWr_q      <= pixWr_d;
      req_q        <= req_d;
      wallX_q      <= wallX_d;
      lineHeight_q <= lineHeight_d;
      drawStart_q  <= drawStart_d;
      texture_q    <= texture_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
`ifdef TEX_TIMEOUT_EN
      waitCnt_q    <= waitCnt_d;
      timeoutErr_q <= timeoutErr_d;
`endif
    end
  end

  assign ray_ready_out   = ready_q;
  assign valid_req_out   = req_q;
  assign wallX_out       = wallX_q;
  assign lineheight_out  = lineHeight_q;
  assign drawstart_out   = drawStart_q;
  assign vcount_ray_out  = row_q;
  assign texture_out     = texture_q;
  assign pix_addr_out    = pixAddr_q;
  assign pix_data_out    = pixData_q;
  assign pix_wr_out      = pixWr_q;
  assign column_done_out = done_q;
`ifdef TEX_TIMEOUT_EN
  assign timeout_err_out = timeoutErr_q;
`else
  assign timeout_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_column_tex_requester.sv
// Scoreboard bench for column_tex_requester: expected frame-buffer writes are queued per column
// and popped as the DUT writes; a sampler mock answers each request rise with pixel = vcount.
module tb_column_tex_requester;

  logic        pixelClk;
  logic        rstN;
  logic        rayValid;
  logic        rayReady;
  logic [8:0]  hcountRay;
  logic [7:0]  lineHeightIn;
  logic [9:0]  drawStartIn;
  logic [15:0] wallXIn;
  logic [3:0]  mapData;
  logic        validReq;
  logic [15:0] wallXOut;
  logic [7:0]  lineHeightOut;
  logic [9:0]  drawStartOut;
  logic [7:0]  vcountRay;
  logic [3:0]  textureOut;
  logic [7:0]  texPixel;
  logic        validTex;
  logic [15:0] pixAddr;
  logic [7:0]  pixData;
  logic        pixWr;
  logic        columnDone;
  logic        timeoutErr;

  int          vectors = 0;
  int          miscompares = 0;
  logic [23:0] expQ[$];
  logic [23:0] monExp;
  int          reqCount;
  int          maxVcount;
  bit          mockOn;
  int          mockDelay;
  bit          reqPrev;
  logic [15:0] latWallX;
  logic [7:0]  latLineHeight;
  logic [9:0]  latDrawStart;
  logic [3:0]  latTexture;
  logic        readyAtDone;
  logic        readyAfterDone;
  logic        doneAfterDone;

  column_tex_requester dut (
    .pixel_clk_in    (pixelClk),
    .rst_n_in        (rstN),
    .ray_valid_in    (rayValid),
    .ray_ready_out   (rayReady),
    .hcount_ray_in   (hcountRay),
    .lineheight_in   (lineHeightIn),
    .drawstart_in    (drawStartIn),
    .wallX_in        (wallXIn),
    .map_data_in     (mapData),
    .valid_req_out   (validReq),
    .wallX_out       (wallXOut),
    .lineheight_out  (lineHeightOut),
    .drawstart_out   (drawStartOut),
    .vcount_ray_out  (vcountRay),
    .texture_out     (textureOut),
    .tex_pixel_in    (texPixel),
    .valid_tex_in    (validTex),
    .pix_addr_out    (pixAddr),
    .pix_data_out    (pixData),
    .pix_wr_out      (pixWr),
    .column_done_out (columnDone),
    .timeout_err_out (timeoutErr)
  );

  initial pixelClk = 1'b0;
  always #5 pixelClk = ~pixelClk;

  // Scoreboard consumer: every write strobe must match the next queued expectation.
  always @(negedge pixelClk) begin
    if (rstN && pixWr) begin
      vectors++;
      if (expQ.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write got addr=%0d data=%h, required no write", pixAddr, pixData);
      end else begin
        monExp = expQ.pop_front();
        if ({pixAddr, pixData} !== monExp) begin
          miscompares++;
          $display("[TB] FAIL fb_write got addr=%0d data=%h, required addr=%0d data=%h",
                   pixAddr, pixData, monExp[23:8], monExp[7:0]);
        end
      end
    end
    if (int'(vcountRay) > maxVcount) maxVcount = int'(vcountRay);
  end

  // Sampler mock: answers mockDelay WAIT cycles after each request rise with pixel = vcount.
  initial begin
    validTex = 1'b0;
    texPixel = 8'h00;
    reqPrev  = 1'b0;
    forever begin
      @(negedge pixelClk);
      if (validReq && !reqPrev) begin
        reqCount++;
        reqPrev = 1'b1;
        if (mockOn) begin
          repeat (mockDelay - 1) @(negedge pixelClk);
          validTex = 1'b1;
          texPixel = vcountRay;
          @(negedge pixelClk);
          validTex = 1'b0;
          texPixel = 8'h00;
        end
      end else begin
        reqPrev = validReq;
      end
    end
  end

  function automatic logic [7:0] expPixel(int r, int ds, int lh, int md, bit answered);
    if (r < ds) return 8'h11;
    if (r < ds + lh) begin
      if (md >= 2 && md <= 9 && answered) return 8'(r);
      return 8'h33;
    end
    return 8'h22;
  endfunction

  task automatic runColumn(input int hc, input int ds, input int lh, input int md,
                           input logic [15:0] wx, input bit answered, output int cycles);
    int  cnt;
    bit  doneSeen;
    for (int r = 0; r < 180; r++)
      expQ.push_back({16'(hc + r * 320), expPixel(r, ds, lh, md, answered)});
    reqCount  = 0;
    maxVcount = 0;
    @(negedge pixelClk);
    hcountRay    = 9'(hc);
    drawStartIn  = 10'(ds);
    lineHeightIn = 8'(lh);
    mapData      = 4'(md);
    wallXIn      = wx;
    rayValid     = 1'b1;
    cnt = 0;
    while (!rayReady && cnt < 50) begin
      @(negedge pixelClk);
      cnt++;
    end
    cycles   = 0;
    doneSeen = 1'b0;
    while (!doneSeen && cycles < 10000) begin
      @(negedge pixelClk);
      cycles++;
      if (cycles == 1) begin
        rayValid      = 1'b0;
        latWallX      = wallXOut;
        latLineHeight = lineHeightOut;
        latDrawStart  = drawStartOut;
        latTexture    = textureOut;
      end
      if (columnDone) doneSeen = 1'b1;
    end
    vectors++;
    if (!doneSeen) begin
      miscompares++;
      $display("[TB] FAIL column_done_timeout got no done after %0d cycles, required a done pulse", cycles);
    end
    readyAtDone = rayReady;
    @(negedge pixelClk);
    doneAfterDone  = columnDone;
    readyAfterDone = rayReady;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    rayValid = 1'b0;
    hcountRay = '0; lineHeightIn = '0; drawStartIn = '0; wallXIn = '0; mapData = '0;
    #12;
    vectors++;
    if ({rayReady, validReq, wallXOut, lineHeightOut, drawStartOut, vcountRay, textureOut,
         pixAddr, pixData, pixWr, columnDone, timeoutErr} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs got ready=%b req=%b addr=%0d wr=%b done=%b, required all 0",
               rayReady, validReq, pixAddr, pixWr, columnDone);
    end
    @(negedge pixelClk);
    rstN = 1'b1;
    @(negedge pixelClk);
    vectors++;
    if (rayReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_reset got %b, required 1", rayReady);
    end
  endtask

  task automatic test_no_wall();
    int cycles;
    runColumn(5, 60, 0, 3, 16'h1234, 1'b1, cycles);
    vectors++;
    if (cycles !== 182) begin
      miscompares++;
      $display("[TB] FAIL no_wall_latency got %0d, required 182", cycles);
    end
    vectors++;
    if (reqCount !== 0) begin
      miscompares++;
      $display("[TB] FAIL no_wall_requests got %0d, required 0", reqCount);
    end
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL no_wall_writes_missing got %0d left, required 0", expQ.size());
    end
    vectors++;
    if ({readyAtDone, readyAfterDone, doneAfterDone} !== 3'b010) begin
      miscompares++;
      $display("[TB] FAIL done_ready_order got readyAtDone=%b readyAfter=%b doneAfter=%b, required 0 1 0",
               readyAtDone, readyAfterDone, doneAfterDone);
    end
    expQ.delete();
  endtask

  task automatic test_textured();
    int cycles;
    mockDelay = 20;
    runColumn(0, 10, 4, 3, 16'hBEEF, 1'b1, cycles);
    vectors++;
    if (reqCount !== 4) begin
      miscompares++;
      $display("[TB] FAIL textured_requests got %0d, required 4", reqCount);
    end
    vectors++;
    if (cycles !== 182 + 4 * 21) begin
      miscompares++;
      $display("[TB] FAIL textured_latency got %0d, required %0d", cycles, 182 + 4 * 21);
    end
    vectors++;
    if ({latWallX, latLineHeight, latDrawStart, latTexture} !== {16'hBEEF, 8'd4, 10'd10, 4'd3}) begin
      miscompares++;
      $display("[TB] FAIL latched_ray got wx=%h lh=%0d ds=%0d tex=%0d, required wx=beef lh=4 ds=10 tex=3",
               latWallX, latLineHeight, latDrawStart, latTexture);
    end
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL textured_writes_missing got %0d left, required 0", expQ.size());
    end
`ifndef TEX_TIMEOUT_EN
    vectors++;
    if (timeoutErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_tied_low got %b, required 0", timeoutErr);
    end
`endif
    expQ.delete();
  endtask

  task automatic test_untextured_wall();
    int cycles;
    runColumn(17, 0, 180, 1, 16'h0042, 1'b1, cycles);
    vectors++;
    if (reqCount !== 0) begin
      miscompares++;
      $display("[TB] FAIL untextured_requests got %0d, required 0", reqCount);
    end
    vectors++;
    if (cycles !== 182) begin
      miscompares++;
      $display("[TB] FAIL untextured_latency got %0d, required 182", cycles);
    end
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL untextured_writes_missing got %0d left, required 0", expQ.size());
    end
    expQ.delete();
  endtask

  task automatic test_clipped_span();
    int cycles;
    mockDelay = 1;
    runColumn(319, 100, 200, 2, 16'h00FF, 1'b1, cycles);
    vectors++;
    if (reqCount !== 80) begin
      miscompares++;
      $display("[TB] FAIL clipped_requests got %0d, required 80", reqCount);
    end
    vectors++;
    if (maxVcount > 179) begin
      miscompares++;
      $display("[TB] FAIL clipped_max_row got %0d, required <= 179", maxVcount);
    end
    vectors++;
    if (cycles !== 182 + 80 * 2) begin
      miscompares++;
      $display("[TB] FAIL clipped_latency got %0d, required %0d", cycles, 182 + 80 * 2);
    end
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL clipped_writes_missing got %0d left, required 0", expQ.size());
    end
    expQ.delete();
  endtask

`ifdef TEX_TIMEOUT_EN
  task automatic test_timeout();
    int cycles;
    vectors++;
    if (timeoutErr !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL timeout_initial got %b, required 0", timeoutErr);
    end
    mockOn = 1'b0;
    runColumn(3, 10, 2, 5, 16'h0001, 1'b0, cycles);
    mockOn = 1'b1;
    vectors++;
    if (timeoutErr !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL timeout_flag got %b, required 1", timeoutErr);
    end
    vectors++;
    if (cycles !== 182 + 2 * 65) begin
      miscompares++;
      $display("[TB] FAIL timeout_latency got %0d, required %0d", cycles, 182 + 2 * 65);
    end
    vectors++;
    if (expQ.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL timeout_writes_missing got %0d left, required 0", expQ.size());
    end
    expQ.delete();
  endtask
`endif

  task automatic test_reset_mid_wait();
    int cnt;
    mockOn = 1'b0;
    @(negedge pixelClk);
    hcountRay = 9'd7; drawStartIn = 10'd0; lineHeightIn = 8'd10; mapData = 4'd4; wallXIn = 16'h0077;
    rayValid = 1'b1;
    cnt = 0;
    while (!validReq && cnt < 50) begin
      @(negedge pixelClk);
      cnt++;
      rayValid = 1'b0;
    end
    rayValid = 1'b0;
    repeat (3) @(negedge pixelClk);
    vectors++;
    if (validReq !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL wait_request_held got %b, required 1", validReq);
    end
    #2 rstN = 1'b0;
    #1;
    vectors++;
    if ({validReq, pixWr, columnDone} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_in_wait got req=%b wr=%b done=%b, required 0 0 0", validReq, pixWr, columnDone);
    end
    @(negedge pixelClk);
    rstN = 1'b1;
    @(negedge pixelClk);
    vectors++;
    if (rayReady !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL ready_after_mid_reset got %b, required 1", rayReady);
    end
    mockOn = 1'b1;
  endtask

  initial begin
    mockOn    = 1'b1;
    mockDelay = 20;
    reqCount  = 0;
    maxVcount = 0;
    test_reset();
    test_no_wall();
    test_textured();
    test_untextured_wall();
    test_clipped_span();
`ifdef TEX_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_wait();
    repeat (4) @(negedge pixelClk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
